data_mem_responder: RTL

//  Responder end of the core's MEM-stage data-memory interface. Accepts one load/store

---
 rtl/data_mem_responder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder end of the core's MEM-stage data-memory port. Accepts one
//   load/store request at a time, waits WAIT_CYCLES extra cycles, then
//   executes the access against a word-organised storage array and returns
//   a one-cycle response with extended load data and an error flag.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_addr              byte address
//   req_write             1 = store, 0 = load
//   req_type              000 B, 001 H, 010 W, 100 BU, 101 HU; others invalid
//   req_wdata             store data (low byte/half used for B/H)
//   resp_valid            one-cycle response strobe
//   resp_rdata, resp_err  registered response payload, held until the next response
module data_mem_responder #(
  parameter int DWIDTH      = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [2:0]            req_type,
  input  logic [DWIDTH-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DWIDTH-1:0]     resp_rdata,
  output logic                  resp_err
);

  localparam int         IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] W4 = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            type_q, type_d;
  logic [DWIDTH-1:0]     wdata_q, wdata_d;
  logic [DWIDTH-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [DWIDTH-1:0]     mem [DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0] op_addr;
  logic                  op_write;
  logic [2:0]            op_type;
  logic [DWIDTH-1:0]     op_wdata;
  logic [1:0]            lane;
  logic [IW-1:0]         idx;
  logic                  oor, bad_type, misalign, bad;
  logic [DWIDTH-1:0]     word, ld_data, st_word;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic                  exec, mem_we;

  // With zero wait states the access executes on the accepting edge, so the
  // operands come straight from the request bus instead of the capture regs.
  always_comb begin
    if (state_q == S_IDLE) begin
      op_addr  = req_addr;
      op_write = req_write;
      op_type  = req_type;
      op_wdata = req_wdata;
    end else begin
      op_addr  = addr_q;
      op_write = write_q;
      op_type  = type_q;
      op_wdata = wdata_q;
    end
  end

  always_comb begin
    lane     = op_addr[1:0];
    idx      = op_addr[IW+1:2];
    oor      = {2'b00, op_addr[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(DEPTH_WORDS);
    bad_type = !(op_type inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misalign = ((op_type[1:0] == 2'b01) && op_addr[0]) ||
               ((op_type[1:0] == 2'b10) && (lane != 2'b00));
    bad      = bad_type || misalign || oor;
    word     = oor ? '0 : mem[idx];
    ld_byte  = word[{lane, 3'b000} +: 8];
    ld_half  = lane[1] ? word[31:16] : word[15:0];

    case (op_type)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h000000, ld_byte};
      3'b101:  ld_data = {16'h0000, ld_half};
      default: ld_data = word;
    endcase

    // Read-modify-write of the addressed word keeps untouched lanes intact.
    st_word = word;
    case (op_type[1:0])
      2'b00:   st_word[{lane, 3'b000} +: 8]    = op_wdata[7:0];
      2'b01:   st_word[{lane[1], 4'b0000} +: 16] = op_wdata[15:0];
      default: st_word = op_wdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    type_d  = type_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    exec    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          write_d = req_write;
          type_d  = req_type;
          wdata_d = req_wdata;
          if (W4 == 4'd0) begin
            state_d = S_RESP;
            exec    = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = W4;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          exec    = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (exec) begin
      err_d   = bad;
      rdata_d = (bad || op_write) ? '0 : ld_data;
    end
  end

  assign mem_we     = exec && op_write && !bad;
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      type_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      type_q  <= type_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset; writes are blocked while reset is held so a request
  // presented during reset cannot slip into the array.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[idx] <= st_word;
    end
  end

endmodule
